// File: rtl/tff_seq_ctrl_pkg.sv
// Shared definitions for the tff access sequencer: FSM states, command opcodes
// and the phase decode applied at the end of a read window.
package tff_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_GAP,
    ST_READ,
    ST_DRAIN,
    ST_CLEAR,
    ST_RESP
  } state_t;

  localparam logic OP_WRITE = 1'b0;
  localparam logic OP_READ  = 1'b1;

  // The hit index includes the synchroniser latency, so it is removed here.
  // A miss reports the full ring length.
  function automatic int unsigned phase_value(input int unsigned hit_idx,
                                              input logic        hit,
                                              input int unsigned segs,
                                              input int unsigned stages);
    if (!hit)
      return segs;
    if (hit_idx < stages)
      return 0;
    return hit_idx - stages;
  endfunction

endpackage

// File: rtl/tff_sync.sv
// N-flop synchroniser with asynchronous reset for one asynchronous input bit.
module tff_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      sr <= '0;
    else
      sr <= {sr[SYNC_STAGES-2:0], d};
  end

  assign q = sr[SYNC_STAGES-1];

endmodule

// File: rtl/tff_seq_ctrl.sv
// Clocked sequencer in front of the asynchronous tff ring cell: turns commands
// into WE/RE/rstb pulses and decodes the read window into phase and carry.
module tff_seq_ctrl
  import tff_seq_ctrl_pkg::*;
#(
  parameter int unsigned RING_SEGS   = 59,
  parameter int unsigned CNT_W       = 6,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_op,
  input  logic [CNT_W-1:0] cmd_len,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [CNT_W-1:0] rsp_value,
  output logic             rsp_carry,
  output logic             tff_we,
  output logic             tff_re,
  output logic             tff_rstb,
  input  logic             tff_out,
  input  logic             tff_carry
);

  localparam int unsigned IDX_W = $clog2(RING_SEGS + SYNC_STAGES + 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] len_cnt;
  logic [IDX_W-1:0] idx, hit_idx;
  logic             hit;
  logic             out_s, carry_s;
  logic             accept, observe;
  logic             we_d, re_d, rstb_d, ready_d, valid_d;

  tff_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_out (
    .clk (clk),
    .rst (rst),
    .d   (tff_out),
    .q   (out_s)
  );

  tff_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_carry (
    .clk (clk),
    .rst (rst),
    .d   (tff_carry),
    .q   (carry_s)
  );

  assign accept  = (state == ST_IDLE) && cmd_ready && cmd_valid;
  assign observe = (state == ST_READ) || (state == ST_DRAIN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= ST_IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:
        if (accept) begin
          if (cmd_op == OP_READ)
            state_n = ST_READ;
          else if (cmd_len != '0)
            state_n = ST_WRITE;
          else
            state_n = ST_GAP;
        end
      ST_WRITE: if (len_cnt == CNT_W'(1)) state_n = ST_GAP;
      ST_GAP:   state_n = ST_IDLE;
      ST_READ:  if (idx == IDX_W'(RING_SEGS - 1)) state_n = ST_DRAIN;
      ST_DRAIN: if (idx == IDX_W'(RING_SEGS + SYNC_STAGES - 1)) state_n = ST_CLEAR;
      ST_CLEAR: state_n = ST_RESP;
      ST_RESP:  if (rsp_ready) state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered so the async cell
  // only ever sees clean flop-driven pulses aligned with the state they belong to.
  always_comb begin
    we_d    = (state_n == ST_WRITE);
    re_d    = (state_n == ST_READ);
    rstb_d  = (state_n != ST_CLEAR);
    ready_d = (state_n == ST_IDLE);
    valid_d = (state_n == ST_RESP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tff_we    <= 1'b0;
      tff_re    <= 1'b0;
      tff_rstb  <= 1'b0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
    end else begin
      tff_we    <= we_d;
      tff_re    <= re_d;
      tff_rstb  <= rstb_d;
      cmd_ready <= ready_d;
      rsp_valid <= valid_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_cnt   <= '0;
      idx       <= '0;
      hit_idx   <= '0;
      hit       <= 1'b0;
      rsp_carry <= 1'b0;
      rsp_value <= '0;
    end else begin
      if (accept)
        len_cnt <= cmd_len;
      else if (state == ST_WRITE)
        len_cnt <= len_cnt - CNT_W'(1);

      if (accept)
        idx <= '0;
      else if (observe)
        idx <= idx + IDX_W'(1);

      if (accept && cmd_op == OP_READ) begin
        hit       <= 1'b0;
        rsp_carry <= 1'b0;
      end else if (observe) begin
        if (out_s && !hit) begin
          hit     <= 1'b1;
          hit_idx <= idx;
        end
        if (carry_s)
          rsp_carry <= 1'b1;
      end

      if (state == ST_CLEAR)
        rsp_value <= CNT_W'(phase_value(32'(hit_idx), hit, RING_SEGS, SYNC_STAGES));
    end
  end

endmodule
